// File: rtl/vga_pkg.sv
// Shared VGA timing constants, control bundle and sizing helpers.
// Ports: none (package).
package vga_pkg;

  // 640x480@60, 25.175 MHz class pixel clock
  localparam int unsigned VGA640_H_DISPLAY = 640;
  localparam int unsigned VGA640_H_FRONT   = 16;
  localparam int unsigned VGA640_H_SYNC    = 96;
  localparam int unsigned VGA640_H_BACK    = 48;
  localparam int unsigned VGA640_V_DISPLAY = 480;
  localparam int unsigned VGA640_V_FRONT   = 10;
  localparam int unsigned VGA640_V_SYNC    = 2;
  localparam int unsigned VGA640_V_BACK    = 33;

  // 800x600@60, 40 MHz pixel clock
  localparam int unsigned VGA800_H_DISPLAY = 800;
  localparam int unsigned VGA800_H_FRONT   = 40;
  localparam int unsigned VGA800_H_SYNC    = 128;
  localparam int unsigned VGA800_H_BACK    = 88;
  localparam int unsigned VGA800_V_DISPLAY = 600;
  localparam int unsigned VGA800_V_FRONT   = 1;
  localparam int unsigned VGA800_V_SYNC    = 4;
  localparam int unsigned VGA800_V_BACK    = 23;

  // Raw (active-high) control flags carried down the alignment pipe
  typedef struct packed {
    logic hs;
    logic vs;
    logic vo;
  } vga_ctl_t;

  function automatic int unsigned vga_total(
    input int unsigned disp,
    input int unsigned fp,
    input int unsigned sync,
    input int unsigned bp
  );
    return disp + fp + sync + bp;
  endfunction

  // Bits needed for a counter running 0..total-1
  function automatic int unsigned vga_cnt_width(
    input int unsigned total
  );
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Clock-enabled shift register, DEPTH stages of WIDTH bits; DEPTH=0 is a wire.
// Ports: clk, rst_n (async clear), en (shift), d (in), q (DEPTH stages later).
module vga_delay_line #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    logic unused_pass;
    assign unused_pass = ^{clk, rst_n, en};
    assign q = d;
  end else begin : g_sr
    logic [DEPTH-1:0][WIDTH-1:0] sr_q;
    logic [DEPTH-1:0][WIDTH-1:0] sr_d;

    always_comb begin
      sr_d = sr_q;
      if (en) begin
        sr_d[0] = d;
        for (int i = 1; i < int'(DEPTH); i++) begin
          sr_d[i] = sr_q[i-1];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sr_q <= '0;
      end else begin
        sr_q <= sr_d;
      end
    end

    assign q = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_core.sv
// Parametrised VGA timing: pixel divider, H/V counters, strobes, and
// sync/blank/colour aligned to a fixed-latency renderer. Ports: clk_100MHz,
// reset_n, enable, rgb_in -> p_tick, x, y, video_on, line_start,
// frame_start, frame_count, hsync, vsync, red, green, blue.
module vga_timing_core
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned H_DISPLAY  = VGA640_H_DISPLAY,
  parameter int unsigned H_FRONT    = VGA640_H_FRONT,
  parameter int unsigned H_SYNC     = VGA640_H_SYNC,
  parameter int unsigned H_BACK     = VGA640_H_BACK,
  parameter int unsigned V_DISPLAY  = VGA640_V_DISPLAY,
  parameter int unsigned V_FRONT    = VGA640_V_FRONT,
  parameter int unsigned V_SYNC     = VGA640_V_SYNC,
  parameter int unsigned V_BACK     = VGA640_V_BACK,
  parameter bit          HS_POL     = 1'b0,
  parameter bit          VS_POL     = 1'b0,
  parameter int unsigned COLOR_BITS = 3,
  parameter int unsigned PIPE_DELAY = 1,
  parameter int unsigned CNT_W      = 10,
  parameter int unsigned FRAME_W    = 8
) (
  input  logic                    clk_100MHz,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [3*COLOR_BITS-1:0] rgb_in,
  output logic                    p_tick,
  output logic [CNT_W-1:0]        x,
  output logic [CNT_W-1:0]        y,
  output logic                    video_on,
  output logic                    line_start,
  output logic                    frame_start,
  output logic [FRAME_W-1:0]      frame_count,
  output logic                    hsync,
  output logic                    vsync,
  output logic [COLOR_BITS-1:0]   red,
  output logic [COLOR_BITS-1:0]   green,
  output logic [COLOR_BITS-1:0]   blue
);

  localparam int unsigned H_TOTAL =
    vga_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL =
    vga_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
  localparam int unsigned DIV_W  = vga_cnt_width(CLK_DIV);
  localparam int unsigned HS_BEG = H_DISPLAY + H_FRONT;
  localparam int unsigned HS_END = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG = V_DISPLAY + V_FRONT;
  localparam int unsigned VS_END = VS_BEG + V_SYNC;
  localparam int unsigned RGB_W  = 3 * COLOR_BITS;

  logic [DIV_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   x_q, x_d;
  logic [CNT_W-1:0]   y_q, y_d;
  logic [FRAME_W-1:0] fc_q, fc_d;
  logic               hs_q, hs_d;
  logic               vs_q, vs_d;
  logic [RGB_W-1:0]   rgb_q, rgb_d;

  logic     tick;
  logic     x_wrap;
  logic     y_wrap;
  vga_ctl_t raw;
  vga_ctl_t dly;

  // reset_n gating keeps the strobe quiet in reset even when CLK_DIV=1
  assign tick   = enable & reset_n &
                  (div_q == DIV_W'(CLK_DIV - 1));
  assign x_wrap = (x_q == CNT_W'(H_TOTAL - 1));
  assign y_wrap = (y_q == CNT_W'(V_TOTAL - 1));

  always_comb begin
    div_d = div_q;
    x_d   = x_q;
    y_d   = y_q;
    fc_d  = fc_q;
    if (enable) begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
    end
    if (tick) begin
      x_d = x_wrap ? '0 : x_q + CNT_W'(1);
      if (x_wrap) begin
        y_d = y_wrap ? '0 : y_q + CNT_W'(1);
        if (y_wrap) begin
          fc_d = fc_q + FRAME_W'(1);
        end
      end
    end
  end

  always_comb begin
    raw    = '0;
    raw.hs = (x_q >= CNT_W'(HS_BEG)) &&
             (x_q <  CNT_W'(HS_END));
    raw.vs = (y_q >= CNT_W'(VS_BEG)) &&
             (y_q <  CNT_W'(VS_END));
    raw.vo = (x_q < CNT_W'(H_DISPLAY)) &&
             (y_q < CNT_W'(V_DISPLAY));
  end

  vga_delay_line #(
    .WIDTH ($bits(vga_ctl_t)),
    .DEPTH (PIPE_DELAY)
  ) u_dly (
    .clk   (clk_100MHz),
    .rst_n (reset_n),
    .en    (tick),
    .d     (raw),
    .q     (dly)
  );

  // Final pin register: sync polarity applied here, colour blanked
  always_comb begin
    hs_d  = hs_q;
    vs_d  = vs_q;
    rgb_d = rgb_q;
    if (tick) begin
      hs_d  = dly.hs ? HS_POL : ~HS_POL;
      vs_d  = dly.vs ? VS_POL : ~VS_POL;
      rgb_d = dly.vo ? rgb_in : '0;
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      fc_q  <= '0;
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      rgb_q <= '0;
    end else begin
      div_q <= div_d;
      x_q   <= x_d;
      y_q   <= y_d;
      fc_q  <= fc_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      rgb_q <= rgb_d;
    end
  end

  assign p_tick      = tick;
  assign x           = x_q;
  assign y           = y_q;
  assign video_on    = raw.vo;
  assign line_start  = tick && (x_q == '0);
  assign frame_start = tick && (x_q == '0) && (y_q == '0);
  assign frame_count = fc_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign red         = rgb_q[RGB_W-1 -: COLOR_BITS];
  assign green       = rgb_q[2*COLOR_BITS-1 -: COLOR_BITS];
  assign blue        = rgb_q[COLOR_BITS-1:0];

endmodule

// File: doc/vga_timing_core.md
Name: vga_timing_core

Overview:
- Parametrised successor to the board's fixed 640x480 VGA controller.
- Generates pixel tick, H/V counters, sync, blanking and line/frame strobes for any VESA-style mode, all in one clock domain with no derived clock edges.
- Accepts RGB from a downstream renderer (staff/note drawer) that has a fixed latency, and aligns sync and blanking to that latency.
- Sits between the renderer and the VGA connector pins.

Parameters:
- CLK_DIV, 4, clk_100MHz cycles per pixel (must be >=1).
- H_DISPLAY, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch.
- H_SYNC, 96, horizontal sync width.
- H_BACK, 48, horizontal back porch.
- V_DISPLAY, 480, visible lines.
- V_FRONT, 10, vertical front porch.
- V_SYNC, 2, vertical sync width.
- V_BACK, 33, vertical back porch.
- HS_POL, 0, active level of hsync.
- VS_POL, 0, active level of vsync.
- COLOR_BITS, 3, bits per colour channel.
- PIPE_DELAY, 1, renderer latency in pixel ticks (0..15).
- CNT_W, 10, width of x/y counters.
- FRAME_W, 8, width of frame counter.

Ports:
- clk_100MHz  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  high = timing runs; low = freeze.
- rgb_in  in  3*COLOR_BITS  renderer colour {r,g,b}, valid PIPE_DELAY ticks after the x/y it belongs to.
- p_tick  out  1  one-clk pulse per pixel.
- x  out  CNT_W  current horizontal count.
- y  out  CNT_W  current vertical count.
- video_on  out  1  undelayed active-area flag (for the renderer).
- line_start  out  1  one-clk pulse.
- frame_start  out  1  one-clk pulse.
- frame_count  out  FRAME_W  completed frames.
- hsync  out  1  aligned horizontal sync.
- vsync  out  1  aligned vertical sync.
- red  out  COLOR_BITS  aligned red.
- green  out  COLOR_BITS  aligned green.
- blue  out  COLOR_BITS  aligned blue.

Behaviour:
- Derived totals: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK; V_TOTAL is built the same way.
- Horizontal line order is display, front porch, sync, back porch. Vertical order is the same.
- Divider counts 0..CLK_DIV-1 and wraps. p_tick is high for exactly the clk cycle in which the divider equals CLK_DIV-1. With CLK_DIV=1, p_tick is constantly high.
- On p_tick:
  - x increments; at H_TOTAL-1, x wraps to 0.
  - y increments only when x wraps; at V_TOTAL-1, y wraps to 0.
  - frame_count increments when y wraps, modulo 2^FRAME_W.
- video_on = (x < H_DISPLAY) && (y < V_DISPLAY). It is combinational from the counters.
- Raw hsync is active while H_DISPLAY+H_FRONT <= x < H_DISPLAY+H_FRONT+H_SYNC. Raw vsync uses the same rule on y.
- line_start = p_tick && x==0.
- frame_start = p_tick && x==0 && y==0.
- Alignment:
  - Raw hsync, vsync and video_on pass through a PIPE_DELAY-stage shift register clocked by clk_100MHz and enabled by p_tick.
  - They are then registered once more, together with rgb_in, on p_tick.
  - Total latency from counter value to pins is PIPE_DELAY+1 pixel ticks for sync, blank and colour alike.
- Blanking: red/green/blue = 0 whenever the delayed video_on is low, regardless of rgb_in.
- hsync/vsync pins output HS_POL/VS_POL when active, and the inverse otherwise.
- enable low:
  - Divider, counters, pipeline and outputs hold their values.
  - p_tick, line_start and frame_start are 0.
  - Resuming continues from the held state with no skipped pixel.
- Reset (reset_n low, asynchronous):
  - Divider, x, y and frame_count = 0.
  - Pipeline stages = inactive sync, video_on 0.
  - hsync = ~HS_POL, vsync = ~VS_POL, rgb = 0.
  - p_tick, line_start and frame_start = 0.
  - Reset mid-line or mid-frame restarts at (0,0).
  - After deassertion, the first p_tick occurs CLK_DIV clk cycles later.
- Simultaneous events: the x wrap, y wrap and frame_count increment on the final pixel of a frame all occur in the same clk cycle.

Decomposition:
- Package vga_pkg holds:
  - default 640x480@60 timing constants;
  - an 800x600 alternative set;
  - a function computing totals and the counter width needed.
- Sub-module vga_delay_line: a parametrised (WIDTH, DEPTH) shift register with a clock enable and async active-low clear. DEPTH=0 acts as a pass-through.
- vga_timing_core instantiates vga_delay_line once, WIDTH=3 (hsync, vsync, video_on).

Test Plan:
- Default params, release reset → p_tick every 4 clk; hsync low for exactly 96 ticks starting 656+2 ticks after line_start; line period 800 ticks; frame period 525 lines; vsync low for 2 lines.
- Drive rgb_in = 9'h1FF only when the delayed video_on is set, PIPE_DELAY=3 → first white pixel on pins exactly 4 ticks after x=0,y=0; pins show 0 during x>=640 and y>=480.
- CLK_DIV=1, H_DISPLAY=8, porches=2/2/2, V_DISPLAY=4, V porches=1/1/1 → line of 14 clk, frame of 98 clk; frame_count increments by 1 per frame and wraps 255→0.
- Hold enable low for 37 clk at x=100,y=10 → x, y, divider and pins frozen; no strobes; next p_tick arrives at the same divider phase and advances to x=101.
- Assert reset_n low mid-frame at x=500,y=300 → hsync=1, vsync=1, rgb=0, x=y=0 immediately (asynchronous); first line_start and frame_start arrive 4 clk after release.
- HS_POL=1, VS_POL=1 → hsync/vsync idle low, pulse high during the sync windows; the reset value is low.
